elixirchip_es1_spu_op_logic: RTL

//  Runtime-selectable bitwise logic operator for the SPU datapath: 8 opcodes (AND..ORN) over two

---
 rtl/elixirchip_es1_spu_op_logic.sv | 116 +++++++++++
 1 files changed

// File: rtl/elixirchip_es1_spu_op_logic.sv
// elixirchip_es1_spu_op_logic
// Runtime-selectable bitwise logic operator (AND..ORN) for the SPU datapath,
// with an optional accumulate mode that folds each valid beat into a running
// register, followed by a LATENCY-deep {data,valid} output pipeline.

module elixirchip_es1_spu_op_logic #(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA      = '0,
  parameter data_t ACC_INIT        = '0,
  parameter data_t RESET_DATA      = '0,
  parameter bit    IMMEDIATE_DATA1 = 1'b0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cke,
  input  logic [2:0] s_op,
  input  logic       s_accum,
  input  data_t      s_data0,
  input  data_t      s_data1,
  input  logic       s_clear,
  input  logic       s_valid,
  output data_t      m_data,
  output logic       m_valid
);

  // Elaboration-time parameter sanity
  if (LATENCY < 0) begin : g_bad_latency
    $error("elixirchip_es1_spu_op_logic: LATENCY must be >= 0");
  end

  if (DEVICE == "" || SIMULATION == "" || DEBUG == "") begin : g_bad_options
    $error("elixirchip_es1_spu_op_logic: DEVICE/SIMULATION/DEBUG must not be empty");
  end

  // s_data1 is used directly either way; a constant operand simply lets
  // synthesis fold the operator logic.
  if (IMMEDIATE_DATA1) begin : g_immediate_b
  end

  data_t acc_q;
  data_t acc_d;
  data_t op_a;
  data_t op_result;
  data_t stage0_data;
  logic  clear_beat;

  assign clear_beat = s_valid & s_clear;

  // Stage 0: operand select, bitwise operator and clear substitution
  always_comb begin
    op_a = s_accum ? acc_q : s_data0;
    case (s_op)
      3'd0:    op_result = op_a & s_data1;
      3'd1:    op_result = op_a | s_data1;
      3'd2:    op_result = op_a ^ s_data1;
      3'd3:    op_result = ~(op_a & s_data1);
      3'd4:    op_result = ~(op_a | s_data1);
      3'd5:    op_result = ~(op_a ^ s_data1);
      3'd6:    op_result = op_a & ~s_data1;
      3'd7:    op_result = op_a | ~s_data1;
      default: op_result = op_a & s_data1;
    endcase
    stage0_data = clear_beat ? CLEAR_DATA : op_result;
  end

  // Accumulator next state: every valid beat loads it, clear beats reinitialise
  always_comb begin
    acc_d = acc_q;
    if (s_valid) begin
      acc_d = s_clear ? ACC_INIT : op_result;
    end
  end

  // Accumulator register; reset overrides cke, cke=0 freezes it
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= ACC_INIT;
    end else if (cke) begin
      acc_q <= acc_d;
    end
  end

  if (LATENCY == 0) begin : g_comb_out
    assign m_data  = stage0_data;
    assign m_valid = s_valid;
  end else begin : g_pipe_out
    data_t pipe_data_q  [LATENCY];
    logic  pipe_valid_q [LATENCY];

    // Output pipeline: reset flushes in-flight beats, every cke cycle advances
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LATENCY; i++) begin
          pipe_data_q[i]  <= RESET_DATA;
          pipe_valid_q[i] <= 1'b0;
        end
      end else if (cke) begin
        pipe_data_q[0]  <= stage0_data;
        pipe_valid_q[0] <= s_valid;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_data_q[i]  <= pipe_data_q[i-1];
          pipe_valid_q[i] <= pipe_valid_q[i-1];
        end
      end
    end

    assign m_data  = pipe_data_q[LATENCY-1];
    assign m_valid = pipe_valid_q[LATENCY-1];
  end

endmodule
